// File: rtl/wb_arbiter2.sv
// Two-master Wishbone-classic arbiter in front of a single slave port.
// Registers the winning request, holds the grant until ack, and kills hung cycles with a timeout.
module wb_arbiter2 #(
  parameter int AW        = 15,
  parameter int DW        = 32,
  parameter int TOW       = 6,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic          m0_we_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic          m1_we_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_we_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic          grant_o,
  output logic          tmo_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Counter starts at 0 in the first BUSY cycle, so this value marks the 2**TOW-1'th BUSY cycle.
  localparam logic [TOW-1:0] CNT_LAST = {TOW{1'b1}} - TOW'(1);

  state_t          state, state_nxt;
  logic [TOW-1:0]  cnt;
  logic            win, start, gnt_stb, tmo_hit, done, ack_any;
  logic [DW-1:0]   rdata;

  always_comb begin
    state_nxt = state;
    win       = grant_o;
    start     = 1'b0;
    done      = 1'b0;
    gnt_stb   = grant_o ? m1_stb_i : m0_stb_i;
    tmo_hit   = (cnt == CNT_LAST);
    case (state)
      IDLE: begin
        if (m0_stb_i && m1_stb_i) win = FIXED_PRI ? 1'b0 : ~grant_o;
        else                      win = m1_stb_i;
        start = m0_stb_i | m1_stb_i;
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        done = s_ack_i | tmo_hit | ~gnt_stb;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A real ack wins over a coincident timeout; reset suppresses any completion.
    ack_any  = rst_n && (state == BUSY) && (s_ack_i || tmo_hit);
    tmo_o    = rst_n && (state == BUSY) && tmo_hit && !s_ack_i;
    rdata    = s_ack_i ? s_dat_i : '1;
    m0_ack_o = ack_any & ~grant_o;
    m1_ack_o = ack_any & grant_o;
    m0_dat_o = m0_ack_o ? rdata : '0;
    m1_dat_o = m1_ack_o ? rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_stb_o <= 1'b0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      grant_o <= 1'b1;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        grant_o <= win;
        s_stb_o <= 1'b1;
        cnt     <= '0;
        s_adr_o <= win ? m1_adr_i : m0_adr_i;
        s_dat_o <= win ? m1_dat_i : m0_dat_i;
        s_we_o  <= win ? m1_we_i  : m0_we_i;
      end
      if (state == BUSY) begin
        cnt <= cnt + TOW'(1);
        if (done) begin
          s_stb_o <= 1'b0;
          s_we_o  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_wb_arbiter2;

  localparam int AW      = 15;
  localparam int DW      = 32;
  localparam int TOW     = 6;
  localparam int TMO_CYC = (1 << TOW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mst_adr [2];
  logic [DW-1:0] mst_dat [2];
  logic          mst_we  [2];
  logic          mst_stb [2];
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m1_ack_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic          s_we_o, s_stb_o;
  logic [DW-1:0] s_rdat;
  logic          s_ack;
  logic          grant_o, tmo_o;

  logic [DW-1:0] fp_m0_dat, fp_m1_dat, fp_s_dat;
  logic          fp_m0_ack, fp_m1_ack, fp_s_we, fp_s_stb, fp_grant, fp_tmo, fp_s_ack;
  logic [AW-1:0] fp_s_adr;

  always #5 clk = ~clk;

  assign fp_s_ack = fp_s_stb;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TOW(TOW), .FIXED_PRI(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(mst_adr[0]), .m0_dat_i(mst_dat[0]), .m0_we_i(mst_we[0]), .m0_stb_i(mst_stb[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_adr_i(mst_adr[1]), .m1_dat_i(mst_dat[1]), .m1_we_i(mst_we[1]), .m1_stb_i(mst_stb[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .grant_o(grant_o), .tmo_o(tmo_o)
  );

  wb_arbiter2 #(.AW(AW), .DW(DW), .TOW(TOW), .FIXED_PRI(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(mst_adr[0]), .m0_dat_i(mst_dat[0]), .m0_we_i(mst_we[0]), .m0_stb_i(mst_stb[0]),
    .m0_dat_o(fp_m0_dat), .m0_ack_o(fp_m0_ack),
    .m1_adr_i(mst_adr[1]), .m1_dat_i(mst_dat[1]), .m1_we_i(mst_we[1]), .m1_stb_i(mst_stb[1]),
    .m1_dat_o(fp_m1_dat), .m1_ack_o(fp_m1_ack),
    .s_adr_o(fp_s_adr), .s_dat_o(fp_s_dat), .s_we_o(fp_s_we), .s_stb_o(fp_s_stb),
    .s_dat_i(s_rdat), .s_ack_i(fp_s_ack), .grant_o(fp_grant), .tmo_o(fp_tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the slave, which BUSY cycle it is, and the latched request.
  bit            e_busy;
  int            e_own;
  int            e_cyc;
  bit            e_last;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_wdat;
  bit            e_we;
  bit            last_ack;

  int            remaining [2];
  bit            back2back, raw_drive, force_read, slave_fixed, fp_check, log_grants;
  int            slave_mode;
  logic [DW-1:0] fixed_val;
  bit            prev_stb, fp_prev_stb;
  int            dut_cyc, tmo_at, tmo_count, we_hi, fp_rises;
  logic [DW-1:0] m1_ack_dat;
  int            grant_log [$];

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_busy = 1'b0; e_own = 0; e_cyc = 0; e_last = 1'b1;
    e_adr = '0; e_wdat = '0; e_we = 1'b0; last_ack = 1'b0;
  endtask

  task automatic new_req(input int i);
    mst_stb[i] = 1'b1;
    mst_adr[i] = AW'($urandom);
    mst_dat[i] = $urandom;
    mst_we[i]  = force_read ? 1'b0 : 1'($urandom_range(0, 1));
    remaining[i]--;
  endtask

  task automatic drive_raw(input bit s0, input bit s1);
    mst_stb[0] = s0; mst_stb[1] = s1;
    for (int i = 0; i < 2; i++) begin
      mst_adr[i] = AW'($urandom);
      mst_dat[i] = $urandom;
      mst_we[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  // One clock: advance the model at the edge, drive the slave, then check and drive masters.
  task automatic apply_stimulus();
    bit [1:0]      exp_ack;
    bit            exp_tmo;
    logic [DW-1:0] rd;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (e_busy) begin
      if (last_ack || !mst_stb[e_own]) begin e_busy = 1'b0; e_we = 1'b0; end
      else e_cyc++;
    end else if (mst_stb[0] || mst_stb[1]) begin
      if (mst_stb[0] && mst_stb[1]) e_own = e_last ? 0 : 1;
      else                          e_own = mst_stb[1] ? 1 : 0;
      e_last = (e_own == 1); e_busy = 1'b1; e_cyc = 1;
      e_adr = mst_adr[e_own]; e_wdat = mst_dat[e_own]; e_we = mst_we[e_own];
    end
    #1;
    s_rdat = slave_fixed ? fixed_val : $urandom;
    case (slave_mode)
      0:       s_ack = e_busy;
      1:       s_ack = ($urandom_range(0, 2) == 0);
      3:       s_ack = e_busy && (e_cyc == TMO_CYC);
      default: s_ack = 1'b0;
    endcase
    @(negedge clk);
    exp_ack = '0; exp_tmo = 1'b0; rd = '0;
    if (e_busy && rst_n) begin
      if (s_ack) begin exp_ack[e_own] = 1'b1; rd = s_rdat; end
      else if (e_cyc == TMO_CYC) begin exp_ack[e_own] = 1'b1; rd = '1; exp_tmo = 1'b1; end
    end
    last_ack = |exp_ack;
    check_output("s_stb", 64'(s_stb_o), 64'(e_busy));
    check_output("s_adr", 64'(s_adr_o), 64'(e_adr));
    check_output("s_dat", 64'(s_dat_o), 64'(e_wdat));
    check_output("s_we", 64'(s_we_o), 64'(e_we));
    check_output("grant", 64'(grant_o), 64'(e_last));
    check_output("m0_ack", 64'(m0_ack_o), 64'(exp_ack[0]));
    check_output("m1_ack", 64'(m1_ack_o), 64'(exp_ack[1]));
    check_output("m0_dat", 64'(m0_dat_o), 64'(exp_ack[0] ? rd : '0));
    check_output("m1_dat", 64'(m1_dat_o), 64'(exp_ack[1] ? rd : '0));
    check_output("tmo", 64'(tmo_o), 64'(exp_tmo));
    if (fp_check && fp_s_stb && !fp_prev_stb) begin
      fp_rises++;
      check_output("fp_grant", 64'(fp_grant), mst_stb[0] ? 64'd0 : 64'd1);
    end
    fp_prev_stb = fp_s_stb;
    if (s_stb_o) begin
      dut_cyc = prev_stb ? dut_cyc + 1 : 1;
      if (!prev_stb && log_grants) grant_log.push_back(int'(grant_o));
    end
    if (tmo_o) begin tmo_at = dut_cyc; tmo_count++; end
    if (s_we_o) we_hi++;
    if (m1_ack_o) m1_ack_dat = m1_dat_o;
    prev_stb = s_stb_o;
    if (!raw_drive) begin
      for (int i = 0; i < 2; i++) begin
        if (exp_ack[i] || !mst_stb[i]) begin
          if (remaining[i] > 0 && (back2back || $urandom_range(0, 1) == 1)) new_req(i);
          else mst_stb[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic apply_reset();
    mst_stb[0] = 1'b0; mst_stb[1] = 1'b0;
    remaining[0] = 0; remaining[1] = 0;
    rst_n = 1'b0;
    apply_stimulus();
    apply_stimulus();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && (remaining[0] > 0 || remaining[1] > 0 ||
                                   mst_stb[0] || mst_stb[1] || e_busy); k++)
      apply_stimulus();
    apply_stimulus();
  endtask

  initial begin
    int tc;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      mst_adr[i] = '0; mst_dat[i] = '0; mst_we[i] = 1'b0; mst_stb[i] = 1'b0; remaining[i] = 0;
    end
    rst_n = 1'b0; s_ack = 1'b0; s_rdat = '0;
    back2back = 1'b1; raw_drive = 1'b0; force_read = 1'b0; slave_fixed = 1'b0;
    fp_check = 1'b0; log_grants = 1'b0; slave_mode = 0; fixed_val = '0;
    prev_stb = 1'b0; fp_prev_stb = 1'b0; dut_cyc = 0; tmo_at = 0; tmo_count = 0;
    we_hi = 0; fp_rises = 0; m1_ack_dat = '0;

    // Single m0 write with a zero-wait slave.
    apply_reset();
    mst_adr[0] = 15'h0010; mst_dat[0] = 32'hA5A5A5A5; mst_we[0] = 1'b1; mst_stb[0] = 1'b1;
    we_hi = 0;
    for (int k = 0; k < 6; k++) apply_stimulus();
    check_output("t1_we_cycles", 64'(we_hi), 64'd1);
    check_output("t1_grant", 64'(grant_o), 64'd0);

    // Both masters back-to-back under round-robin.
    apply_reset();
    grant_log.delete();
    log_grants = 1'b1;
    remaining[0] = 3; remaining[1] = 3;
    drain(60);
    log_grants = 1'b0;
    check_output("t2_grants", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < grant_log.size() && i < 6; i++)
      check_output("t2_order", 64'(grant_log[i]), 64'(i % 2));

    // Fixed-priority instance with both masters streaming, then m0 idle, then random.
    fp_check = 1'b1; raw_drive = 1'b1; fp_rises = 0;
    for (int k = 0; k < 20; k++) begin apply_stimulus(); drive_raw(1'b1, 1'b1); end
    for (int k = 0; k < 10; k++) begin apply_stimulus(); drive_raw(1'b0, 1'b1); end
    for (int k = 0; k < 30; k++) begin
      apply_stimulus();
      drive_raw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    mst_stb[0] = 1'b0; mst_stb[1] = 1'b0;
    apply_stimulus();
    fp_check = 1'b0; raw_drive = 1'b0;
    for (int k = 0; k < 3; k++) apply_stimulus();
    n_tests++;
    assert (fp_rises >= 10) else begin
      n_fail++;
      $error("[TB] FAIL t3_fp_grants: observed %0d expected at least 10", fp_rises);
    end

    // m1 read against a slave that never answers.
    force_read = 1'b1; slave_mode = 2; tmo_at = 0; tc = tmo_count;
    remaining[1] = 1;
    drain(120);
    check_output("t4_tmo_cycle", 64'(tmo_at), 64'(TMO_CYC));
    check_output("t4_tmo_pulses", 64'(tmo_count), 64'(tc + 1));

    // Ack arriving in the very cycle the timeout would fire.
    slave_mode = 3; slave_fixed = 1'b1; fixed_val = 32'h12345678; m1_ack_dat = '0;
    tc = tmo_count;
    remaining[1] = 1;
    drain(120);
    check_output("t5_data", 64'(m1_ack_dat), 64'h12345678);
    check_output("t5_no_tmo", 64'(tmo_count), 64'(tc));
    slave_fixed = 1'b0; force_read = 1'b0;

    // Reset in the middle of a BUSY cycle while the slave acks.
    slave_mode = 2;
    remaining[0] = 1;
    for (int k = 0; k < 5; k++) apply_stimulus();
    check_output("t6_busy", 64'(s_stb_o), 64'd1);
    rst_n = 1'b0; s_ack = 1'b1;
    #1;
    check_output("t6_m0_ack", 64'(m0_ack_o), 64'd0);
    check_output("t6_m1_ack", 64'(m1_ack_o), 64'd0);
    apply_stimulus();
    rst_n = 1'b1; mst_stb[0] = 1'b0; remaining[0] = 0;
    apply_stimulus();
    check_output("t6_grant", 64'(grant_o), 64'd1);
    check_output("t6_adr", 64'(s_adr_o), 64'd0);

    // Randomized traffic with random slave wait states.
    apply_reset();
    slave_mode = 1; back2back = 1'b0;
    remaining[0] = 25; remaining[1] = 25;
    drain(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
